// File: rtl/branch_control_ras_pkg.sv
// Shared types and constants for the branch control stage with return-address stacks.
package branch_control_ras_pkg;

    localparam int ADDRESS_SIZE        = 32;
    localparam int REGISTER_SIZE       = 32;
    localparam int HW_LANE             = 4;
    localparam int THREAD_NUMB_DEFAULT = 4;
    localparam int THREAD_ID_WIDTH     = 2;
    localparam int SCOREBOARD_LENGTH   = 16;
    localparam int RAS_DEPTH_DEFAULT   = 8;
    localparam int RAS_RET_OFFSET      = 4;

    typedef logic [ADDRESS_SIZE-1:0]              address_t;
    typedef logic [REGISTER_SIZE-1:0]             register_t;
    typedef register_t [HW_LANE-1:0]              hw_lane_t;
    typedef logic [SCOREBOARD_LENGTH-1:0]         scoreboard_t;
    typedef logic [THREAD_ID_WIDTH-1:0]           thread_id_t;
    typedef logic [$clog2(RAS_DEPTH_DEFAULT)-1:0] ras_ptr_t;
    typedef logic [$clog2(RAS_DEPTH_DEFAULT):0]   ras_cnt_t;

    typedef enum logic [5:0] {
        ADD        = 6'h00,
        JMP        = 6'h18,
        JMPSR      = 6'h19,
        JERET      = 6'h1A,
        JRET       = 6'h1B,
        BRANCH_EQZ = 6'h1C,
        BRANCH_NEZ = 6'h1D,
        NOP        = 6'h3F
    } opcode_t;

    typedef enum logic {
        JBA = 1'b0,  // absolute base address
        JRA = 1'b1   // pc-relative
    } branch_type_t;

    typedef enum logic [1:0] {
        PIPE_INT    = 2'd0,
        PIPE_MEM    = 2'd1,
        PIPE_BRANCH = 2'd2,
        PIPE_SPM    = 2'd3
    } pipe_sel_t;

    typedef struct packed {
        address_t     pc;
        opcode_t      op_code;
        logic         is_branch;
        branch_type_t branch_type;
        pipe_sel_t    pipe_sel;
        thread_id_t   thread_id;
    } instruction_decoded_t;

    // Conditional branches always compute a pc-relative target.
    function automatic logic is_conditional(input opcode_t op);
        return (op == BRANCH_EQZ) || (op == BRANCH_NEZ);
    endfunction

endpackage

// File: rtl/branch_ras.sv
// Circular return-address stack for one hardware thread. When full, a push
// overwrites the oldest entry; a pop on an empty stack is ignored.
module branch_ras
    import branch_control_ras_pkg::*;
#(
    parameter int RAS_DEPTH = RAS_DEPTH_DEFAULT
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  logic     pop,
    input  logic     flush,
    input  address_t push_data,
    output address_t top_data,
    output logic     empty,
    output logic     full
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] top;
    logic [PTR_W-1:0] top_inc;
    logic [CNT_W-1:0] count;
    address_t         mem [RAS_DEPTH];

    assign top_inc  = top + PTR_W'(1);
    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(RAS_DEPTH));
    assign top_data = mem[top];

    // Pointer and occupancy bookkeeping; a flush overrides any same-cycle push or pop.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            top   <= '0;
            count <= '0;
        end else if (flush) begin
            top   <= '0;
            count <= '0;
        end else if (push) begin
            top <= top_inc;
            if (!full) count <= count + CNT_W'(1);
        end else if (pop && !empty) begin
            top   <= top - PTR_W'(1);
            count <= count - CNT_W'(1);
        end
    end

    // Stack storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; the count marks which entries are meaningful.
        if (push && !flush) mem[top_inc] <= push_data;
    end

endmodule

// File: rtl/branch_control_ras.sv
// Branch resolution stage: decides jumps, computes targets, keeps one
// return-address stack per thread and registers all results for one-cycle latency.
module branch_control_ras
    import branch_control_ras_pkg::*;
#(
    parameter int THREAD_NUMB  = THREAD_NUMB_DEFAULT,
    parameter int RAS_DEPTH    = RAS_DEPTH_DEFAULT,
    parameter int RET_FROM_RAS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 opf_valid,
    input  instruction_decoded_t opf_inst_scheduled,
    input  hw_lane_t             opf_fetched_op0,
    input  hw_lane_t             opf_fetched_op1,
    input  scoreboard_t          opf_destination_bitmap,
    input  logic                 ras_flush_valid,
    input  thread_id_t           ras_flush_thread_id,
    output logic                 bc_rollback_enable,
    output logic                 bc_rollback_valid,
    output address_t             bc_rollback_pc,
    output thread_id_t           bc_rollback_thread_id,
    output scoreboard_t          bc_scoreboard,
    output logic                 bc_ras_overflow,
    output logic                 bc_ras_underflow,
    output logic                 bc_ras_mismatch
);

    localparam address_t RET_OFFSET = address_t'(RAS_RET_OFFSET);

    logic     acc;
    logic     taken;
    logic     is_jmpsr;
    logic     is_jret;
    address_t op0;
    address_t op1;
    address_t target;
    address_t cur_top;
    logic     cur_empty;
    logic     cur_full;
    logic     unused_lanes;

    address_t ras_top   [THREAD_NUMB];
    logic     ras_empty [THREAD_NUMB];
    logic     ras_full  [THREAD_NUMB];

    assign acc          = opf_valid && (opf_inst_scheduled.pipe_sel == PIPE_BRANCH);
    assign op0          = opf_fetched_op0[0];
    assign op1          = opf_fetched_op1[0];
    assign unused_lanes = ^{opf_fetched_op0[HW_LANE-1:1], opf_fetched_op1[HW_LANE-1:1]};

    // One stack per thread; push and pop are steered by the instruction's thread id.
    for (genvar t = 0; t < THREAD_NUMB; t++) begin : g_ras
        logic sel;
        assign sel = (opf_inst_scheduled.thread_id == thread_id_t'(t));

        branch_ras #(.RAS_DEPTH(RAS_DEPTH)) u_ras (
            .clk      (clk),
            .reset    (reset),
            .push     (acc && is_jmpsr && sel),
            .pop      (acc && is_jret && sel),
            .flush    (ras_flush_valid && (ras_flush_thread_id == thread_id_t'(t))),
            .push_data(opf_inst_scheduled.pc + RET_OFFSET),
            .top_data (ras_top[t]),
            .empty    (ras_empty[t]),
            .full     (ras_full[t])
        );
    end

    assign cur_top   = ras_top[opf_inst_scheduled.thread_id];
    assign cur_empty = ras_empty[opf_inst_scheduled.thread_id];
    assign cur_full  = ras_full[opf_inst_scheduled.thread_id];

    // Jump decision from op_code and condition operand.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        taken    = 1'b0;
        is_jmpsr = 1'b0;
        is_jret  = 1'b0;
        if (opf_inst_scheduled.is_branch) begin
            case (opf_inst_scheduled.op_code)
                JMP, JERET: taken = 1'b1;
                JMPSR: begin
                    taken    = 1'b1;
                    is_jmpsr = 1'b1;
                end
                JRET: begin
                    taken   = 1'b1;
                    is_jret = 1'b1;
                end
                BRANCH_EQZ: taken = (op0 == '0);
                BRANCH_NEZ: taken = (op0 != '0);
                default:    taken = 1'b0;
            endcase
        end
    end

    // Target mux; returns come from the stack only when it holds an entry.
    always_comb begin
        target = '0;
        if (taken) begin
            if (is_jret)
                target = ((RET_FROM_RAS != 0) && !cur_empty) ? cur_top : op0;
            else if (is_conditional(opf_inst_scheduled.op_code) ||
                     (opf_inst_scheduled.branch_type == JRA))
                target = opf_inst_scheduled.pc + op1;
            else
                target = op0;
        end
    end

    // Registered results: pulses clear on idle cycles, pc/thread/scoreboard hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bc_rollback_enable    <= 1'b0;
            bc_rollback_valid     <= 1'b0;
            bc_rollback_pc        <= '0;
            bc_rollback_thread_id <= '0;
            bc_scoreboard         <= '0;
            bc_ras_overflow       <= 1'b0;
            bc_ras_underflow      <= 1'b0;
            bc_ras_mismatch       <= 1'b0;
        end else begin
            bc_rollback_enable <= acc && taken;
            bc_rollback_valid  <= acc && !taken;
            bc_ras_overflow    <= acc && is_jmpsr && cur_full;
            bc_ras_underflow   <= acc && is_jret && cur_empty;
            bc_ras_mismatch    <= acc && is_jret && (RET_FROM_RAS == 0) &&
                                  !cur_empty && (cur_top != op0);
            if (acc) begin
                bc_rollback_pc        <= target;
                bc_rollback_thread_id <= opf_inst_scheduled.thread_id;
                bc_scoreboard         <= opf_destination_bitmap;
            end
        end
    end

endmodule

// File: tb/tb_branch_control_ras.sv
// Self-checking bench: two DUTs (return target from RAS, and RAS check-only)
// share stimulus and are compared against a list-based stack model.
module tb_branch_control_ras;
    import branch_control_ras_pkg::*;

    localparam int NT    = 4;
    localparam int DEPTH = 8;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 opf_valid;
    instruction_decoded_t inst;
    hw_lane_t             op0, op1;
    scoreboard_t          sb;
    logic                 fl_v;
    thread_id_t           fl_t;

    logic en1, val1, ov1, un1, mm1, en0, val0, ov0, un0, mm0;
    address_t pc1, pc0;
    thread_id_t tid1, tid0;
    scoreboard_t sb1, sb0;

    branch_control_ras #(.THREAD_NUMB(NT), .RAS_DEPTH(DEPTH), .RET_FROM_RAS(1)) dut_ret (
        .clk(clk), .reset(reset), .opf_valid(opf_valid), .opf_inst_scheduled(inst),
        .opf_fetched_op0(op0), .opf_fetched_op1(op1), .opf_destination_bitmap(sb),
        .ras_flush_valid(fl_v), .ras_flush_thread_id(fl_t),
        .bc_rollback_enable(en1), .bc_rollback_valid(val1), .bc_rollback_pc(pc1),
        .bc_rollback_thread_id(tid1), .bc_scoreboard(sb1), .bc_ras_overflow(ov1),
        .bc_ras_underflow(un1), .bc_ras_mismatch(mm1));

    branch_control_ras #(.THREAD_NUMB(NT), .RAS_DEPTH(DEPTH), .RET_FROM_RAS(0)) dut_chk (
        .clk(clk), .reset(reset), .opf_valid(opf_valid), .opf_inst_scheduled(inst),
        .opf_fetched_op0(op0), .opf_fetched_op1(op1), .opf_destination_bitmap(sb),
        .ras_flush_valid(fl_v), .ras_flush_thread_id(fl_t),
        .bc_rollback_enable(en0), .bc_rollback_valid(val0), .bc_rollback_pc(pc0),
        .bc_rollback_thread_id(tid0), .bc_scoreboard(sb0), .bc_ras_overflow(ov0),
        .bc_ras_underflow(un0), .bc_ras_mismatch(mm0));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: per-thread list, oldest at index 0, newest at size-1.
    address_t    hist [NT][DEPTH];
    int          size [NT];
    logic        exp_en, exp_val, exp_ov, exp_un, exp_mm0;
    address_t    exp_pc1, exp_pc0;
    thread_id_t  exp_tid;
    scoreboard_t exp_sb;

    typedef struct {
        opcode_t      op;
        branch_type_t bt;
        pipe_sel_t    ps;
        address_t     pc;
        address_t     a;
        address_t     b;
        logic         en;
        logic         val;
        address_t     tpc;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int t = 0; t < NT; t++) size[t] = 0;
        exp_en = 0; exp_val = 0; exp_ov = 0; exp_un = 0; exp_mm0 = 0;
        exp_pc1 = '0; exp_pc0 = '0; exp_tid = '0; exp_sb = '0;
    endtask

    task automatic model_push(input int t, input address_t v);
        if (size[t] == DEPTH) begin
            for (int i = 0; i < DEPTH - 1; i++) hist[t][i] = hist[t][i+1];
            hist[t][DEPTH-1] = v;
        end else begin
            hist[t][size[t]] = v;
            size[t]++;
        end
    endtask

    task automatic set_inst(input logic v, input opcode_t op, input branch_type_t bt,
                            input pipe_sel_t ps, input int tid, input address_t pc,
                            input address_t a, input address_t b);
        opf_valid           = v;
        inst.pc             = pc;
        inst.op_code        = op;
        inst.is_branch      = !(op == ADD || op == NOP);
        inst.branch_type    = bt;
        inst.pipe_sel       = ps;
        inst.thread_id      = thread_id_t'(tid);
        for (int l = 1; l < HW_LANE; l++) begin
            op0[l] = $urandom;
            op1[l] = $urandom;
        end
        op0[0] = a;
        op1[0] = b;
        sb     = scoreboard_t'($urandom);
    endtask

    task automatic check_all();
        check("enable_ras", 32'(en1), 32'(exp_en));
        check("enable_chk", 32'(en0), 32'(exp_en));
        check("valid_ras", 32'(val1), 32'(exp_val));
        check("valid_chk", 32'(val0), 32'(exp_val));
        check("pc_ras", pc1, exp_pc1);
        check("pc_chk", pc0, exp_pc0);
        check("tid_ras", 32'(tid1), 32'(exp_tid));
        check("tid_chk", 32'(tid0), 32'(exp_tid));
        check("sb_ras", 32'(sb1), 32'(exp_sb));
        check("sb_chk", 32'(sb0), 32'(exp_sb));
        check("ovf_ras", 32'(ov1), 32'(exp_ov));
        check("ovf_chk", 32'(ov0), 32'(exp_ov));
        check("unf_ras", 32'(un1), 32'(exp_un));
        check("unf_chk", 32'(un0), 32'(exp_un));
        check("mis_ras", 32'(mm1), 32'(0));
        check("mis_chk", 32'(mm0), 32'(exp_mm0));
    endtask

    // Predict from the current inputs, clock once, compare, then drop flush.
    task automatic step();
        logic acc, taken, jmpsr, jret, emp, ful, dropped;
        address_t topv, t1, t0;
        int tid;
        tid   = int'(inst.thread_id);
        acc   = opf_valid && (inst.pipe_sel == PIPE_BRANCH);
        jmpsr = inst.is_branch && (inst.op_code == JMPSR);
        jret  = inst.is_branch && (inst.op_code == JRET);
        taken = 1'b0;
        if (inst.is_branch) begin
            case (inst.op_code)
                JMP, JMPSR, JERET, JRET: taken = 1'b1;
                BRANCH_EQZ:              taken = (op0[0] == 0);
                BRANCH_NEZ:              taken = (op0[0] != 0);
                default:                 taken = 1'b0;
            endcase
        end
        emp  = (size[tid] == 0);
        ful  = (size[tid] == DEPTH);
        topv = emp ? '0 : hist[tid][size[tid]-1];
        if (!taken) begin
            t1 = '0; t0 = '0;
        end else if (jret) begin
            t1 = emp ? op0[0] : topv;
            t0 = op0[0];
        end else if (inst.op_code == BRANCH_EQZ || inst.op_code == BRANCH_NEZ ||
                     inst.branch_type == JRA) begin
            t1 = inst.pc + op1[0]; t0 = t1;
        end else begin
            t1 = op0[0]; t0 = t1;
        end
        exp_en  = acc && taken;
        exp_val = acc && !taken;
        exp_ov  = acc && jmpsr && ful;
        exp_un  = acc && jret && emp;
        exp_mm0 = acc && jret && !emp && (topv != op0[0]);
        if (acc) begin
            exp_pc1 = t1; exp_pc0 = t0; exp_tid = inst.thread_id; exp_sb = sb;
        end
        dropped = fl_v && (int'(fl_t) == tid);
        if (acc && !dropped) begin
            if (jmpsr) model_push(tid, inst.pc + 4);
            else if (jret && !emp) size[tid]--;
        end
        if (fl_v) size[int'(fl_t)] = 0;
        @(posedge clk);
        #1;
        check_all();
        fl_v = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_en"}, 32'({en1, en0}), 32'(0));
        check({tag, "_val"}, 32'({val1, val0}), 32'(0));
        check({tag, "_pc_ras"}, pc1, 32'(0));
        check({tag, "_pc_chk"}, pc0, 32'(0));
        check({tag, "_tid"}, 32'({tid1, tid0}), 32'(0));
        check({tag, "_sb_ras"}, 32'(sb1), 32'(0));
        check({tag, "_sb_chk"}, 32'(sb0), 32'(0));
        check({tag, "_flags"}, 32'({ov1, un1, mm1, ov0, un0, mm0}), 32'(0));
    endtask

    initial begin
        opcode_t ops [8];
        ops = '{ADD, JMP, JMPSR, JERET, JRET, BRANCH_EQZ, BRANCH_NEZ, JRET};

        vecs[0] = '{BRANCH_EQZ, JRA, PIPE_BRANCH, 32'h100, 32'h0, 32'hFFFF_FFF4, 1'b1, 1'b0, 32'hF4};
        vecs[1] = '{BRANCH_EQZ, JRA, PIPE_BRANCH, 32'h100, 32'h5, 32'hFFFF_FFF4, 1'b0, 1'b1, 32'h0};
        vecs[2] = '{BRANCH_NEZ, JBA, PIPE_BRANCH, 32'h100, 32'h5, 32'h40, 1'b1, 1'b0, 32'h140};
        vecs[3] = '{BRANCH_NEZ, JRA, PIPE_BRANCH, 32'h100, 32'h0, 32'h40, 1'b0, 1'b1, 32'h0};
        vecs[4] = '{JMP, JBA, PIPE_BRANCH, 32'h300, 32'h1234, 32'h8, 1'b1, 1'b0, 32'h1234};
        vecs[5] = '{JMP, JRA, PIPE_BRANCH, 32'hFFFF_FFF0, 32'h77, 32'h20, 1'b1, 1'b0, 32'h10};
        vecs[6] = '{JERET, JBA, PIPE_BRANCH, 32'h500, 32'h800, 32'h4, 1'b1, 1'b0, 32'h800};
        vecs[7] = '{ADD, JBA, PIPE_BRANCH, 32'h600, 32'h0, 32'h4, 1'b0, 1'b1, 32'h0};
        vecs[8] = '{JMP, JBA, PIPE_INT, 32'h700, 32'h999, 32'h4, 1'b0, 1'b0, 32'h0};

        fl_v = 1'b0;
        fl_t = '0;
        set_inst(1'b0, NOP, JBA, PIPE_INT, 0, '0, '0, '0);
        model_clear();

        // Asynchronous reset at start: outputs must be zero before any clock edge.
        #1 reset = 1'b1;
        #1 check_zero_outputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;

        // Table-driven stateless jumps and branches.
        for (int i = 0; i < 9; i++) begin
            set_inst(1'b1, vecs[i].op, vecs[i].bt, vecs[i].ps, i % NT,
                     vecs[i].pc, vecs[i].a, vecs[i].b);
            step();
            check($sformatf("vec%0d_en", i), 32'(en1), 32'(vecs[i].en));
            check($sformatf("vec%0d_val", i), 32'(val1), 32'(vecs[i].val));
            check($sformatf("vec%0d_pc", i), pc1, vecs[i].tpc);
        end

        // Call/return on thread 2; thread 3 must stay empty.
        set_inst(1'b1, JMPSR, JBA, PIPE_BRANCH, 2, 32'h200, 32'h1000, 32'h0);
        step();
        set_inst(1'b1, JRET, JBA, PIPE_BRANCH, 2, 32'h1000, 32'hDEAD, 32'h0);
        step();
        check("t2_ret_pc", pc1, 32'h204);
        check("t2_ret_unf", 32'(un1), 32'(0));
        set_inst(1'b1, JRET, JBA, PIPE_BRANCH, 3, 32'h1100, 32'hBEEF, 32'h0);
        step();
        check("t3_empty_unf", 32'(un1), 32'(1));

        // Overflow: nine calls on thread 0, then nine returns.
        for (int i = 0; i < 9; i++) begin
            set_inst(1'b1, JMPSR, JBA, PIPE_BRANCH, 0, address_t'(4 * i), 32'h2000, 32'h0);
            step();
            check($sformatf("ovf_call%0d", i), 32'(ov1), 32'(i == 8));
        end
        for (int i = 0; i < 8; i++) begin
            set_inst(1'b1, JRET, JBA, PIPE_BRANCH, 0, 32'h2000, 32'h0, 32'h0);
            step();
            check($sformatf("ovf_ret%0d", i), pc1, address_t'(32'h24 - 4 * i));
        end
        set_inst(1'b1, JRET, JBA, PIPE_BRANCH, 0, 32'h2000, 32'h40, 32'h0);
        step();
        check("ovf_final_unf", 32'(un1), 32'(1));
        check("ovf_final_pc", pc1, 32'h40);

        // Check-only return: target from op0 and mismatch flag.
        set_inst(1'b1, JMPSR, JBA, PIPE_BRANCH, 1, 32'h10, 32'h3000, 32'h0);
        step();
        set_inst(1'b1, JRET, JBA, PIPE_BRANCH, 1, 32'h3000, 32'h30, 32'h0);
        step();
        check("chk_ret_pc", pc0, 32'h30);
        check("chk_mismatch", 32'(mm0), 32'(1));

        // Flush coinciding with a call on the same thread drops the push.
        set_inst(1'b1, JMPSR, JBA, PIPE_BRANCH, 1, 32'h80, 32'h4000, 32'h0);
        fl_v = 1'b1;
        fl_t = 2'd1;
        step();
        check("flush_call_en", 32'(en1), 32'(1));
        set_inst(1'b1, JRET, JBA, PIPE_BRANCH, 1, 32'h4000, 32'h88, 32'h0);
        step();
        check("flush_ret_unf", 32'(un1), 32'(1));

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            opcode_t op;
            int tid;
            address_t a;
            op  = ops[$urandom_range(0, 7)];
            tid = $urandom_range(0, NT - 1);
            a   = ($urandom_range(0, 1) == 0) ? '0 : address_t'($urandom);
            if (op == JRET && size[tid] > 0 && $urandom_range(0, 1) == 0)
                a = hist[tid][size[tid]-1];
            set_inst($urandom_range(0, 3) != 0, op, branch_type_t'($urandom_range(0, 1)),
                     ($urandom_range(0, 7) == 0) ? PIPE_MEM : PIPE_BRANCH, tid,
                     address_t'($urandom), a, address_t'($urandom));
            if ($urandom_range(0, 15) == 0) begin
                fl_v = 1'b1;
                fl_t = thread_id_t'($urandom_range(0, NT - 1));
                if (int'(fl_t) == tid && (op == JMPSR || op == JRET))
                    fl_t = thread_id_t'(tid + 1);
            end
            step();
        end

        // Reset asserted between edges while a jump is being reported.
        set_inst(1'b1, JMPSR, JBA, PIPE_BRANCH, 0, 32'h900, 32'h5000, 32'h0);
        step();
        set_inst(1'b1, JMP, JBA, PIPE_BRANCH, 0, 32'h5000, 32'h6000, 32'h0);
        step();
        check("pre_reset_en", 32'(en1), 32'(1));
        set_inst(1'b0, NOP, JBA, PIPE_INT, 0, '0, '0, '0);
        #2 reset = 1'b1;
        #1 check_zero_outputs("midreset");
        model_clear();
        @(posedge clk);
        @(negedge clk) reset = 1'b0;
        set_inst(1'b1, JRET, JBA, PIPE_BRANCH, 0, 32'h6000, 32'h70, 32'h0);
        step();
        check("post_reset_unf", 32'(un1), 32'(1));
        check("post_reset_pc", pc1, 32'h70);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
